// File: rtl/seg_link_pkg.sv
// ============================================================================
// seg_link_pkg: shared widths, segment patterns and FSM states of the display link.
// Revision 1.0
// ============================================================================
`default_nettype none

package seg_link_pkg;

   localparam int DISP_W  = 2;
   localparam int SEG_W   = 3;
   localparam int TUPLE_W = DISP_W + SEG_W + 1;

   localparam logic [DISP_W-1:0] DISP_LAST = 2'd3;
   localparam logic [SEG_W-1:0]  SEG_LAST  = 3'd6;

   // Active-low patterns, bit0 = a ... bit6 = g
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DIG0  = 7'h40;
   localparam logic [6:0] SEG_DIG1  = 7'h79;
   localparam logic [6:0] SEG_DIG2  = 7'h24;
   localparam logic [6:0] SEG_DIG3  = 7'h30;
   localparam logic [6:0] SEG_DIG4  = 7'h19;
   localparam logic [6:0] SEG_DIG5  = 7'h12;
   localparam logic [6:0] SEG_DIG6  = 7'h02;
   localparam logic [6:0] SEG_DIG7  = 7'h78;
   localparam logic [6:0] SEG_DIG8  = 7'h00;
   localparam logic [6:0] SEG_DIG9  = 7'h10;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/seg_pattern_decode.sv
// ============================================================================
// seg_pattern_decode: active-low 7-segment pattern to BCD digit, flags unknown patterns.
// Revision 1.0
// ============================================================================
`default_nettype none

module seg_pattern_decode
   import seg_link_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] digit,
   output logic       invalid
);

   always_comb begin
      digit   = 4'hF;
      invalid = 1'b0;
      case (pattern)
         SEG_DIG0:  digit = 4'd0;
         SEG_DIG1:  digit = 4'd1;
         SEG_DIG2:  digit = 4'd2;
         SEG_DIG3:  digit = 4'd3;
         SEG_DIG4:  digit = 4'd4;
         SEG_DIG5:  digit = 4'd5;
         SEG_DIG6:  digit = 4'd6;
         SEG_DIG7:  digit = 4'd7;
         SEG_DIG8:  digit = 4'd8;
         SEG_DIG9:  digit = 4'd9;
         SEG_BLANK: digit = 4'hF;
         default:   invalid = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/seg_stream_rx.sv
// ============================================================================
// seg_stream_rx: synchronize/filter the 6-wire display link, rebuild and decode 4 digits.
// Optional frame watchdog: FRAME_TIMEOUT_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module seg_stream_rx
   import seg_link_pkg::*;
#(
   parameter int STABLE_CYCLES  = 16,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic              i_CLK,
   input  logic              i_RST,
   input  logic [DISP_W-1:0] i_disp_sel,
   input  logic [SEG_W-1:0]  i_seg_sel,
   input  logic              i_seg_bit,
   output logic [3:0]        o_Q0,
   output logic [3:0]        o_Q1,
   output logic [3:0]        o_Q2,
   output logic [3:0]        o_Q3,
   output logic              o_valid,
   output logic              o_err
);

   localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

   generate
      if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1)
      begin : g_param_check
         $error("seg_stream_rx: parameter out of range");
      end
   endgenerate

   logic [TUPLE_W-1:0]             link_tuple;
   logic [SYNC_STAGES*TUPLE_W-1:0] sync_sr;
   logic [SYNC_STAGES-1:0]         sync_vld;
   logic [TUPLE_W-1:0]             sync_tuple;
   logic [TUPLE_W-1:0]             prev_tuple;
   logic                           prev_vld;
   logic                           same;
   logic [7:0]                     stab_cnt;
   logic                           acc;
   logic [TUPLE_W-1:0]             acc_tuple;

   assign link_tuple = {i_disp_sel, i_seg_sel, i_seg_bit};
   assign sync_tuple = sync_sr[SYNC_STAGES*TUPLE_W-1 -: TUPLE_W];
   assign same       = prev_vld && (sync_tuple == prev_tuple);

   // sync_vld keeps reset-time flop contents from ever looking like a stable tuple
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         sync_sr  <= '0;
         sync_vld <= '0;
      end else begin
         sync_sr  <= {sync_sr[(SYNC_STAGES-1)*TUPLE_W-1:0], link_tuple};
         sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
      end
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         prev_tuple <= '0;
         prev_vld   <= 1'b0;
         stab_cnt   <= '0;
         acc        <= 1'b0;
         acc_tuple  <= '0;
      end else begin
         prev_tuple <= sync_tuple;
         prev_vld   <= sync_vld[SYNC_STAGES-1];
         acc_tuple  <= prev_tuple;
         acc        <= 1'b0;
         if (!same) begin
            stab_cnt <= '0;
         end else if (stab_cnt != STABLE_LAST) begin
            stab_cnt <= stab_cnt + 8'd1;
            acc      <= (stab_cnt == STABLE_LAST - 8'd1);
         end
      end
   end

   logic [DISP_W-1:0] acc_disp;
   logic [SEG_W-1:0]  acc_seg;
   logic              acc_bit;
   logic              acc_is_start;

   assign {acc_disp, acc_seg, acc_bit} = acc_tuple;
   assign acc_is_start = (acc_disp == '0) && (acc_seg == '0);

   rx_state_t         state, state_nx;
   logic [DISP_W-1:0] exp_disp, exp_disp_nx;
   logic [SEG_W-1:0]  exp_seg, exp_seg_nx;
   logic [3:0][6:0]   shadow;
   logic              shadow_we;
   logic              seq_err;
   logic              load_out;
   logic              clear_out;
   logic              timeout;

`ifdef FRAME_TIMEOUT_EN
   logic [31:0] to_cnt;

   always_ff @(posedge i_CLK) begin
      if (i_RST || acc || state != COLLECT) begin
         to_cnt <= '0;
      end else if (!timeout) begin
         to_cnt <= to_cnt + 32'd1;
      end
   end

   assign timeout = (state == COLLECT) && (to_cnt >= 32'(TIMEOUT_CYCLES));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state    <= HUNT;
         exp_disp <= '0;
         exp_seg  <= '0;
         shadow   <= {4{SEG_BLANK}};
      end else begin
         state    <= state_nx;
         exp_disp <= exp_disp_nx;
         exp_seg  <= exp_seg_nx;
         if (shadow_we) begin
            shadow[acc_disp][acc_seg] <= acc_bit;
         end
      end
   end

   always_comb begin
      state_nx    = state;
      exp_disp_nx = exp_disp;
      exp_seg_nx  = exp_seg;
      shadow_we   = 1'b0;
      seq_err     = 1'b0;
      load_out    = 1'b0;
      clear_out   = 1'b0;
      case (state)
         HUNT: begin
            if (acc && acc_is_start) begin
               shadow_we   = 1'b1;
               exp_disp_nx = '0;
               exp_seg_nx  = 3'd1;
               state_nx    = COLLECT;
            end
         end
         COLLECT: begin
            if (acc) begin
               if (acc_disp == exp_disp && acc_seg == exp_seg) begin
                  shadow_we = 1'b1;
                  if (acc_seg == SEG_LAST) begin
                     exp_seg_nx  = '0;
                     exp_disp_nx = exp_disp + 2'd1;
                     if (acc_disp == DISP_LAST) begin
                        state_nx = DONE;
                     end
                  end else begin
                     exp_seg_nx = exp_seg + 3'd1;
                  end
               end else begin
                  // A misplaced (0,0) is the start of the next frame, not just noise
                  seq_err = 1'b1;
                  if (acc_is_start) begin
                     shadow_we   = 1'b1;
                     exp_disp_nx = '0;
                     exp_seg_nx  = 3'd1;
                  end else begin
                     state_nx = HUNT;
                  end
               end
            end else if (timeout) begin
               seq_err   = 1'b1;
               clear_out = 1'b1;
               state_nx  = HUNT;
            end
         end
         DONE: begin
            load_out = 1'b1;
            state_nx = HUNT;
         end
         default: state_nx = HUNT;
      endcase
   end

   logic [3:0][3:0] dec_digit;
   logic [3:0]      dec_invalid;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dec
         seg_pattern_decode u_dec (
            .pattern (shadow[gi]),
            .digit   (dec_digit[gi]),
            .invalid (dec_invalid[gi])
         );
      end
   endgenerate

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         o_Q0    <= 4'hF;
         o_Q1    <= 4'hF;
         o_Q2    <= 4'hF;
         o_Q3    <= 4'hF;
         o_valid <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (seq_err) begin
            o_err <= 1'b1;
         end
         if (load_out) begin
            o_Q0    <= dec_digit[0];
            o_Q1    <= dec_digit[1];
            o_Q2    <= dec_digit[2];
            o_Q3    <= dec_digit[3];
            o_valid <= 1'b1;
            if (|dec_invalid) begin
               o_err <= 1'b1;
            end
         end
         if (clear_out) begin
            o_Q0 <= 4'hF;
            o_Q1 <= 4'hF;
            o_Q2 <= 4'hF;
            o_Q3 <= 4'hF;
         end
      end
   end

endmodule

`default_nettype wire
